operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter OPW, default 6: opcode field width carried through the stage.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 n_rst  in  1  reset, synchronous, active-low.
REQ-004 in_valid / in_ready  in / out  1 / 1  decode-to-fetch handshake.
REQ-005 in_op  in  OPW, in_imm  in  32, in_dst  in  3, in_wen  in  1  decoded fields.
REQ-006 in_src1, in_src2  in  3 each; in_use1, in_use2  in  1 each  source indices and source-used flags.
REQ-007 ra1, ra2  out  3  register-file read addresses; rd1, rd2  in  32  asynchronous read data.
REQ-008 wb_valid  in  1, wb_addr  in  3, wb_data  in  32  writeback port; also drives register-file we/wa/wd externally.
REQ-009 out_valid / out_ready  out / in  1 / 1  fetch-to-execute handshake.
REQ-010 out_op  out  OPW, out_a  out  32, out_b  out  32, out_imm  out  32, out_dst  out  3, out_wen  out  1  registered operands.

Function
REQ-011 ra1 SHALL equal in_src1 and ra2 SHALL equal in_src2 combinationally.
REQ-012 Scoreboard: 8-bit pending vector, one bit per register.
REQ-013 Hazard SHALL assert when (in_use1 and pending[in_src1]) or (in_use2 and pending[in_src2]) or (in_wen and pending[in_dst]); a pending bit cleared by wb_valid/wb_addr in the same cycle counts as not pending only when BYPASS_EN is defined.
REQ-014 in_ready SHALL be (not out_valid or out_ready) and not hazard.
REQ-015 Accept = in_valid and in_ready; on accept, all out_* fields SHALL load on the next edge and out_valid SHALL become 1 (latency 1 cycle).
REQ-016 out_a/out_b SHALL capture rd1/rd2, except with BYPASS_EN a source equal to wb_addr while wb_valid=1 SHALL capture wb_data.
REQ-017 out_valid=1 and out_ready=0: all out_* SHALL hold unchanged.
REQ-018 out_ready=1 and no accept: out_valid SHALL clear next edge.
REQ-019 Accept with in_wen=1 SHALL set pending[in_dst] next edge.
REQ-020 wb_valid=1 SHALL clear pending[wb_addr] next edge.
REQ-021 Set and clear of the same index in one cycle: set SHALL win.
REQ-022 wb_valid for a non-pending index: no scoreboard change, no error.
REQ-023 in_valid=0: in_ready SHALL still be driven per REQ-014; no state change from upstream.

Reset
REQ-024 n_rst=0 at a posedge SHALL clear pending to 0, out_valid to 0, all out_* data fields to 0.
REQ-025 Reset SHALL override accept and writeback in the same cycle; in-flight output SHALL be discarded.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-027 Macro OPERAND_FETCH_BYPASS_EN: defined -> same-cycle writeback forwarding per REQ-013/REQ-016, RAW on an in-flight writeback costs 0 stall cycles.
REQ-028 Undefined -> no forwarding; source read only after pending clears, RAW costs 1 stall cycle after wb_valid; out_a/out_b always from rd1/rd2.

Verification
REQ-029 Reset, then in_valid with src1=2,src2=3,rd1=0x11,rd2=0x22, out_ready=1 -> next cycle out_valid=1, out_a=0x11, out_b=0x22.
REQ-030 Issue dst=5,in_wen=1; next issue use1 src1=5 -> in_ready=0 until wb_valid addr5; with BYPASS_EN out_a=wb_data (0xDEAD) same cycle, without one extra stall cycle then out_a=rd1.
REQ-031 out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0, second instruction accepted the cycle out_ready rises.
REQ-032 Accept dst=4 in_wen=1 while wb_valid addr4 same cycle -> pending[4]=1 afterwards; following use of r4 stalls.
REQ-033 Assert n_rst=0 with out_valid=1 and pending=0x30 -> next cycle out_valid=0, pending=0, in_ready=1 after release.

Source files
------------

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundles every non-clock signal of the operand fetch stage.
//   slave  modport - the stage's view:
//     decode handshake in, register-file read port out/in,
//     writeback snoop in, execute handshake out.
//   master modport - the surrounding pipeline's view (directions mirrored).
// Parameter OPW: opcode field width; must match the stage's OPW.
interface operand_fetch_if #(
    parameter int unsigned OPW = 6
);
    // decode -> fetch
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [31:0]    in_imm;
    logic [2:0]     in_dst;
    logic           in_wen;
    logic [2:0]     in_src1;
    logic [2:0]     in_src2;
    logic           in_use1;
    logic           in_use2;
    // register-file read port (asynchronous data)
    logic [2:0]     ra1;
    logic [2:0]     ra2;
    logic [31:0]    rd1;
    logic [31:0]    rd2;
    // writeback (also drives the register file externally)
    logic           wb_valid;
    logic [2:0]     wb_addr;
    logic [31:0]    wb_data;
    // fetch -> execute
    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] out_op;
    logic [31:0]    out_a;
    logic [31:0]    out_b;
    logic [31:0]    out_imm;
    logic [2:0]     out_dst;
    logic           out_wen;

    modport slave (
        input  in_valid, in_op, in_imm, in_dst, in_wen, in_src1, in_src2, in_use1, in_use2,
        output in_ready,
        output ra1, ra2,
        input  rd1, rd2,
        input  wb_valid, wb_addr, wb_data,
        output out_valid, out_op, out_a, out_b, out_imm, out_dst, out_wen,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_imm, in_dst, in_wen, in_src1, in_src2, in_use1, in_use2,
        input  in_ready,
        input  ra1, ra2,
        output rd1, rd2,
        output wb_valid, wb_addr, wb_data,
        input  out_valid, out_op, out_a, out_b, out_imm, out_dst, out_wen,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute pipeline stage that reads source operands
// from an external register file and blocks on read-after-write and
// write-after-write hazards using an 8-entry pending-write scoreboard.
//
// Ports:
//   clk    - clock, all state on posedge
//   n_rst  - synchronous active-low reset
//   bus    - operand_fetch_if.slave: decode handshake + fields, register-file
//            read addresses/data, writeback snoop, execute handshake + operands
//
// Parameter OPW: opcode width carried through the stage.
//
// Macro OPERAND_FETCH_BYPASS_EN: when defined, a writeback in the same cycle
// clears the hazard and its data is forwarded into out_a/out_b (no stall).
// When undefined, the instruction waits until the pending bit has cleared and
// then reads the freshly written register file (one extra stall cycle).
module operand_fetch #(
    parameter int unsigned OPW = 6
) (
    input logic            clk,
    input logic            n_rst,
    operand_fetch_if.slave bus
);

    logic [7:0]     pending_q;
    logic [7:0]     pending_d;
    logic [7:0]     pending_eff;
    logic           hazard;
    logic           accept;
    logic [31:0]    opa;
    logic [31:0]    opb;

    logic           out_valid_q;
    logic [OPW-1:0] out_op_q;
    logic [31:0]    out_a_q;
    logic [31:0]    out_b_q;
    logic [31:0]    out_imm_q;
    logic [2:0]     out_dst_q;
    logic           out_wen_q;

    assign bus.ra1 = bus.in_src1;
    assign bus.ra2 = bus.in_src2;

    // Hazard check against the scoreboard; with forwarding a register being
    // written back this cycle is treated as already available.
    always_comb begin
        pending_eff = pending_q;
`ifdef OPERAND_FETCH_BYPASS_EN
        if (bus.wb_valid) begin
            pending_eff[bus.wb_addr] = 1'b0;
        end
`endif
        hazard = (bus.in_use1 && pending_eff[bus.in_src1]) ||
                 (bus.in_use2 && pending_eff[bus.in_src2]) ||
                 (bus.in_wen  && pending_eff[bus.in_dst]);
    end

    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    // Operand selection
    always_comb begin
        opa = bus.rd1;
        opb = bus.rd2;
`ifdef OPERAND_FETCH_BYPASS_EN
        if (bus.wb_valid && (bus.wb_addr == bus.in_src1)) begin
            opa = bus.wb_data;
        end
        if (bus.wb_valid && (bus.wb_addr == bus.in_src2)) begin
            opb = bus.wb_data;
        end
`endif
    end

    // Scoreboard next state: clear first so a same-index set wins.
    always_comb begin
        pending_d = pending_q;
        if (bus.wb_valid) begin
            pending_d[bus.wb_addr] = 1'b0;
        end
        if (accept && bus.in_wen) begin
            pending_d[bus.in_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_imm_q   <= '0;
            out_dst_q   <= '0;
            out_wen_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_op_q    <= bus.in_op;
                out_a_q     <= opa;
                out_b_q     <= opb;
                out_imm_q   <= bus.in_imm;
                out_dst_q   <= bus.in_dst;
                out_wen_q   <= bus.in_wen;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_dst   = out_dst_q;
    assign bus.out_wen   = out_wen_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch.
// A small register-file model sits on the read/writeback ports; expected
// values are hand-computed constants.
module tb_operand_fetch;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_err;

    operand_fetch_if #(.OPW(6)) bus ();

    operand_fetch #(.OPW(6)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Register file: preset r2/r3 on reset, written by the writeback port.
    logic [31:0] rf [8];
    always @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= 32'h0;
            rf[2] <= 32'h11;
            rf[3] <= 32'h22;
        end else if (bus.wb_valid) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end
    assign bus.rd1 = rf[bus.ra1];
    assign bus.rd2 = rf[bus.ra2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_imm   = '0;
        bus.in_dst   = '0;
        bus.in_wen   = 1'b0;
        bus.in_src1  = '0;
        bus.in_src2  = '0;
        bus.in_use1  = 1'b0;
        bus.in_use2  = 1'b0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [31:0] imm, input logic [2:0] dst,
                             input logic wen, input logic [2:0] s1, input logic u1,
                             input logic [2:0] s2, input logic u2);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_imm   = imm;
        bus.in_dst   = dst;
        bus.in_wen   = wen;
        bus.in_src1  = s1;
        bus.in_use1  = u1;
        bus.in_src2  = s2;
        bus.in_use2  = u2;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_rst = 1'b0;
        idle_in();
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_pending", u_dut.pending_q, 0);
        check_eq("rst_out_a", bus.out_a, 0);
        check_eq("rst_out_op", bus.out_op, 0);
        n_rst = 1'b1;
        #1;
        check_eq("rst_in_ready", bus.in_ready, 1);

        // Basic fetch: r2/r3 operands
        set_instr(6'h0A, 32'h1234, 3'd1, 1'b0, 3'd2, 1'b1, 3'd3, 1'b1);
        #1;
        check_eq("ra1", bus.ra1, 2);
        check_eq("ra2", bus.ra2, 3);
        check_eq("basic_in_ready", bus.in_ready, 1);
        tick();
        idle_in();
        check_eq("basic_valid", bus.out_valid, 1);
        check_eq("basic_a", bus.out_a, 32'h11);
        check_eq("basic_b", bus.out_b, 32'h22);
        check_eq("basic_op", bus.out_op, 6'h0A);
        check_eq("basic_imm", bus.out_imm, 32'h1234);
        check_eq("basic_dst", bus.out_dst, 1);
        check_eq("basic_wen", bus.out_wen, 0);
        tick();
        check_eq("drain_valid", bus.out_valid, 0);

        // RAW hazard on r5
        set_instr(6'h01, 32'h0, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        idle_in();
        check_eq("raw_pending", u_dut.pending_q, 8'h20);
        check_eq("raw_prod_dst", bus.out_dst, 5);
        set_instr(6'h02, 32'h0, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0);
        #1;
        check_eq("raw_stall0", bus.in_ready, 0);
        tick();
        check_eq("raw_stall_valid", bus.out_valid, 0);
        check_eq("raw_stall1", bus.in_ready, 0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 3'd5;
        bus.wb_data  = 32'hDEAD;
        #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        check_eq("raw_wb_ready", bus.in_ready, 1);
        tick();
        bus.wb_valid = 1'b0;
        idle_in();
        check_eq("raw_fwd_valid", bus.out_valid, 1);
        check_eq("raw_fwd_a", bus.out_a, 32'hDEAD);
        check_eq("raw_fwd_op", bus.out_op, 6'h02);
        check_eq("raw_fwd_pending", u_dut.pending_q, 0);
`else
        check_eq("raw_wb_ready", bus.in_ready, 0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check_eq("raw_clr_pending", u_dut.pending_q, 0);
        check_eq("raw_clr_ready", bus.in_ready, 1);
        tick();
        idle_in();
        check_eq("raw_rd_valid", bus.out_valid, 1);
        check_eq("raw_rd_a", bus.out_a, 32'hDEAD);
        check_eq("raw_rd_op", bus.out_op, 6'h02);
`endif
        tick();

        // Backpressure: output held for 3 cycles, second instruction waits
        bus.out_ready = 1'b0;
        set_instr(6'h03, 32'hAAAA, 3'd6, 1'b0, 3'd2, 1'b1, 3'd3, 1'b1);
        tick();
        set_instr(6'h04, 32'hBBBB, 3'd7, 1'b0, 3'd3, 1'b1, 3'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_valid", bus.out_valid, 1);
            check_eq("bp_op", bus.out_op, 6'h03);
            check_eq("bp_imm", bus.out_imm, 32'hAAAA);
            check_eq("bp_a", bus.out_a, 32'h11);
            check_eq("bp_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", bus.in_ready, 1);
        tick();
        idle_in();
        check_eq("bp_second_valid", bus.out_valid, 1);
        check_eq("bp_second_op", bus.out_op, 6'h04);
        check_eq("bp_second_imm", bus.out_imm, 32'hBBBB);
        check_eq("bp_second_a", bus.out_a, 32'h22);
        tick();
        check_eq("bp_drain", bus.out_valid, 0);

        // Writeback to a non-pending register leaves scoreboard alone
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 3'd7;
        bus.wb_data  = 32'h77;
        tick();
        bus.wb_valid = 1'b0;
        check_eq("wb_nonpend", u_dut.pending_q, 0);

        // Set and clear of r4 in the same cycle: set wins
        set_instr(6'h05, 32'h0, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 3'd4;
        bus.wb_data  = 32'h4444;
        #1;
        check_eq("setclr_ready", bus.in_ready, 1);
        tick();
        bus.wb_valid = 1'b0;
        idle_in();
        check_eq("setclr_pending", u_dut.pending_q, 8'h10);
        set_instr(6'h06, 32'h0, 3'd0, 1'b0, 3'd4, 1'b1, 3'd0, 1'b0);
        #1;
        check_eq("setclr_stall", bus.in_ready, 0);
        tick();
        check_eq("setclr_stall2", bus.in_ready, 0);
        idle_in();
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 3'd4;
        tick();
        bus.wb_valid = 1'b0;
        check_eq("setclr_cleared", u_dut.pending_q, 0);
        tick();

        // Reset with output in flight and r4/r5 pending
        set_instr(6'h07, 32'h33, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        set_instr(6'h08, 32'h34, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        #1;
        check_eq("pre_rst_ready", bus.in_ready, 1);
        tick();
        idle_in();
        bus.out_ready = 1'b0;
        #1;
        check_eq("pre_rst_pending", u_dut.pending_q, 8'h30);
        check_eq("pre_rst_valid", bus.out_valid, 1);
        check_eq("pre_rst_op", bus.out_op, 6'h08);
        n_rst = 1'b0;
        set_instr(6'h09, 32'h99, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 3'd4;
        tick();
        check_eq("rst2_valid", bus.out_valid, 0);
        check_eq("rst2_pending", u_dut.pending_q, 0);
        check_eq("rst2_op", bus.out_op, 0);
        check_eq("rst2_imm", bus.out_imm, 0);
        check_eq("rst2_dst", bus.out_dst, 0);
        check_eq("rst2_wen", bus.out_wen, 0);
        n_rst = 1'b1;
        idle_in();
        bus.wb_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_eq("rst2_in_ready", bus.in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
